// File: rtl/snake_pkg.sv
// Shared snake-game definitions: status codes, grid and screen limits,
// and the apple_gen FSM encoding.
package snake_pkg;

  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_PLAY    = 2'b10;

  localparam logic [5:0] X_MIN = 6'd1;
  localparam logic [5:0] X_MAX = 6'd38;
  localparam logic [5:0] Y_MIN = 6'd1;
  localparam logic [5:0] Y_MAX = 6'd28;

  localparam int CELL_SHIFT = 4;

  localparam logic [11:0] SCR_W = 12'd640;
  localparam logic [11:0] SCR_H = 12'd480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EAT,
    ST_EAT,
    ST_PLACE
  } apple_st_e;

  function automatic logic cell_in_grid(
    input logic [5:0] x,
    input logic [5:0] y
  );
    return (x >= X_MIN) && (x <= X_MAX) &&
           (y >= Y_MIN) && (y <= Y_MAX);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded on reset.
// Ports: clk, rst (async active-low), q (current state, never zero).
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic        fb;
  logic [15:0] nxt;

  assign fb  = q[15] ^ q[13] ^ q[12] ^ q[10];
  assign nxt = {q[14:0], fb};

  // The all-zero state is a lock-up; fall back to the seed instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else if (nxt == 16'd0) begin
      q <= SEED;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/apple_gen.sv
// Apple source: eat detection, grow pulse, LFSR re-placement, score and
// per-pixel apple flag. Ports: clk, rst (async active-low), game_status,
// head_x/head_y, x_pos/y_pos in; add_cube, apple_x/apple_y, apple_pix,
// score out. Optional blinking of apple_pix under macro APPLE_BLINK_EN.
module apple_gen
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [5:0]  INIT_X    = 6'd24,
  parameter logic [5:0]  INIT_Y    = 6'd10,
  parameter int          ADD_HOLD  = 4,
  parameter int          BLINK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  game_status,
  input  logic [5:0]  head_x,
  input  logic [5:0]  head_y,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  output logic        add_cube,
  output logic [5:0]  apple_x,
  output logic [5:0]  apple_y,
  output logic        apple_pix,
  output logic [7:0]  score
);

  localparam logic [7:0]  HOLD_INIT  = 8'(ADD_HOLD - 1);
  localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);

  apple_st_e   state, state_n;
  logic [7:0]  hold, hold_n;
  logic [7:0]  score_n;
  logic [5:0]  ax_n, ay_n;
  logic        add_n;
  logic [15:0] lfsr;
  logic [5:0]  cx, cy;
  logic        cand_ok, head_hit;
  logic        restart, play;
  logic        pix_base;
  logic        unused_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign cx       = lfsr[5:0];
  assign cy       = lfsr[13:8];
  assign restart  = (game_status == GS_RESTART);
  assign play     = (game_status == GS_PLAY);
  assign head_hit = (head_x == apple_x) && (head_y == apple_y);
  // Rejecting the head cell prevents an immediate second eat.
  assign cand_ok  = cell_in_grid(cx, cy) &&
                    !((cx == head_x) && (cy == head_y));

  assign unused_bits = ^{lfsr[15:14], lfsr[7:6], BLINK_LAST};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      hold     <= 8'd0;
      add_cube <= 1'b0;
      apple_x  <= INIT_X;
      apple_y  <= INIT_Y;
      score    <= 8'd0;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      add_cube <= add_n;
      apple_x  <= ax_n;
      apple_y  <= ay_n;
      score    <= score_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold;
    add_n   = add_cube;
    ax_n    = apple_x;
    ay_n    = apple_y;
    score_n = score;
    if (restart) begin
      state_n = ST_IDLE;
      hold_n  = 8'd0;
      add_n   = 1'b0;
      ax_n    = INIT_X;
      ay_n    = INIT_Y;
      score_n = 8'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (play) state_n = ST_WAIT_EAT;
        end
        ST_WAIT_EAT: begin
          if (play && head_hit) begin
            state_n = ST_EAT;
            add_n   = 1'b1;
            hold_n  = HOLD_INIT;
            if (score != 8'hFF) score_n = score + 8'd1;
          end
        end
        ST_EAT: begin
          if (hold == 8'd0) begin
            add_n   = 1'b0;
            state_n = ST_PLACE;
          end else begin
            hold_n = hold - 8'd1;
          end
        end
        ST_PLACE: begin
          if (cand_ok) begin
            ax_n    = cx;
            ay_n    = cy;
            state_n = ST_WAIT_EAT;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign pix_base = (x_pos < SCR_W) && (y_pos < SCR_H) &&
                    (x_pos[CELL_SHIFT +: 6] == apple_x) &&
                    (y_pos[CELL_SHIFT +: 6] == apple_y) &&
                    (state != ST_PLACE) && (state != ST_EAT);

`ifdef APPLE_BLINK_EN
  logic [23:0] bcnt;
  logic        blink;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt  <= 24'd0;
      blink <= 1'b1;
    end else if (restart) begin
      bcnt  <= 24'd0;
      blink <= 1'b1;
    end else if (bcnt == BLINK_LAST) begin
      bcnt  <= 24'd0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + 24'd1;
    end
  end

  assign apple_pix = pix_base & blink;
`else
  assign apple_pix = pix_base;
`endif

endmodule
